// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the tiny CPU datapath.
// Two combinational read ports (A/B) with write-first bypass, one synchronous
// write port, and a clear engine that sweeps every entry to RESET_VAL.
// Build option: define REG_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
// Handshake: clear_req_in is a level sampled only in IDLE. clear_busy_out is
// high for the DEPTH sweep cycles. clear_done_out pulses for the single cycle
// that follows the last cleared entry. Writes, bypass and further requests are
// ignored whenever the engine is not IDLE.
module reg_file_mp #(
  parameter int                 DATA_W    = 8,
  parameter int                 ADDR_W    = 3,
  parameter logic [DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [ADDR_W-1:0] rd_a_addr_in,
  output logic [DATA_W-1:0] rd_a_data_out,
  input  logic [ADDR_W-1:0] rd_b_addr_in,
  output logic [DATA_W-1:0] rd_b_data_out,
  input  logic [ADDR_W-1:0] write_addr_in,
  input  logic              write_en_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic              clear_req_in,
  output logic              clear_busy_out,
  output logic              clear_done_out,
  output logic [1:0]        fsm_state_out
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SWEEP = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              idle;
  logic              write_ok;

  assign idle           = (state_q == ST_IDLE);
  assign clear_busy_out = (state_q == ST_SWEEP);
  assign clear_done_out = (state_q == ST_DONE);
  assign fsm_state_out  = state_q;

  // Qualify the write: only in IDLE, and never to the hardwired entry 0.
  always_comb begin
    write_ok = idle && write_en_in;
`ifdef REG_FILE_ZERO_REG_EN
    if (write_addr_in == '0) write_ok = 1'b0;
`endif
  end

  // Read port A: stored value, overridden by a same-cycle write (write-first).
  always_comb begin
    rd_a_data_out = mem_q[rd_a_addr_in];
    if (write_ok && (rd_a_addr_in == write_addr_in)) rd_a_data_out = write_data_in;
`ifdef REG_FILE_ZERO_REG_EN
    if (rd_a_addr_in == '0) rd_a_data_out = '0;
`endif
  end

  // Read port B: same rules as port A, fully independent.
  always_comb begin
    rd_b_data_out = mem_q[rd_b_addr_in];
    if (write_ok && (rd_b_addr_in == write_addr_in)) rd_b_data_out = write_data_in;
`ifdef REG_FILE_ZERO_REG_EN
    if (rd_b_addr_in == '0) rd_b_data_out = '0;
`endif
  end

  // Clear engine next state: IDLE -> SWEEP (DEPTH cycles) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_req_in) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
        end
      end
      ST_SWEEP: begin
        if (cnt_q == LAST_IDX) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear engine state and sweep counter.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: port writes in IDLE, one entry cleared per SWEEP cycle.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      if (write_ok) mem_q[write_addr_in] <= write_data_in;
      if (state_q == ST_SWEEP) mem_q[cnt_q] <= RESET_VAL;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (DATA_W=8, ADDR_W=3, RESET_VAL=0): directed vector
// table, hand-written clear/reset sequences, then random traffic against a
// cycle-count based reference model.
module tb_reg_file_mp;

  localparam int DEPTH = 8;
`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] ra = '0, rb = '0, wa = '0;
  logic [7:0] wd = '0;
  logic       we = 1'b0, req = 1'b0;
  logic [7:0] rda, rdb;
  logic       busy, done;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .RESET_VAL(8'h00)) dut (
    .clk_in        (clk),
    .reset_in      (rst_n),
    .rd_a_addr_in  (ra),
    .rd_a_data_out (rda),
    .rd_b_addr_in  (rb),
    .rd_b_data_out (rdb),
    .write_addr_in (wa),
    .write_en_in   (we),
    .write_data_in (wd),
    .clear_req_in  (req),
    .clear_busy_out(busy),
    .clear_done_out(done),
    .fsm_state_out (fsm_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic [7:0]  s_a, s_b;
  logic        s_busy, s_done;
  int          done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_k counts cycles since an accepted clear request: -1 means idle,
  // 0..DEPTH-1 means entry m_k gets cleared at the coming edge,
  // DEPTH means the done cycle.
  logic [7:0] m_mem [DEPTH];
  int         m_k = -1;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    m_k = -1;
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a, input logic w,
                                        input logic [2:0] waddr, input logic [7:0] wdata);
    if (ZERO_EN && a == 3'd0) return 8'h00;
    if (m_k < 0 && w && a == waddr) return wdata;
    return m_mem[a];
  endfunction

  task automatic model_edge(input logic w, input logic [2:0] waddr,
                            input logic [7:0] wdata, input logic r);
    if (m_k < 0) begin
      if (w && !(ZERO_EN && waddr == 3'd0)) m_mem[waddr] = wdata;
      if (r) m_k = 0;
    end else if (m_k < DEPTH) begin
      m_mem[m_k] = 8'h00;
      m_k++;
    end else begin
      m_k = -1;
    end
  endtask

  // One clock cycle: drive, sample at negedge, compare to model, advance.
  task automatic step(input logic w, input logic [2:0] waddr, input logic [7:0] wdata,
                      input logic [2:0] a, input logic [2:0] b, input logic r);
    logic [17:0] e;
    we = w; wa = waddr; wd = wdata; ra = a; rb = b; req = r;
    @(negedge clk);
    s_a = rda; s_b = rdb; s_busy = busy; s_done = done;
    if (s_done) done_seen++;
    exp_q.push_back({m_read(a, w, waddr, wdata), m_read(b, w, waddr, wdata),
                     (m_k >= 0 && m_k < DEPTH), (m_k == DEPTH)});
    e = exp_q.pop_front();
    check("model_rd_a", 32'(s_a), 32'(e[17:10]));
    check("model_rd_b", 32'(s_b), 32'(e[9:2]));
    check("model_busy", 32'(s_busy), 32'(e[1]));
    check("model_done", 32'(s_done), 32'(e[0]));
    @(posedge clk);
    model_edge(w, waddr, wdata, r);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    we = 1'b0; req = 1'b0; ra = 3'd0; rb = 3'd7; wa = '0; wd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_a", 32'(rda), 32'h0);
    check("reset_rd_b", 32'(rdb), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    #2 rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       req;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[9];
  localparam logic [7:0] R0_EXP = ZERO_EN ? 8'h00 : 8'h77;

  int busy_cnt, done_idx;
  logic busy_h[31];
  logic done_h[31];

  initial begin
    vecs[0] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd4, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0, 8'hA5, 8'hA5, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 3'd5, 8'h3C, 3'd5, 3'd4, 1'b0, 8'h3C, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd3, 1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 3'd0, 8'h77, 3'd0, 3'd0, 1'b0, R0_EXP, R0_EXP, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 3'd0, 8'h00, 3'd0, 3'd5, 1'b0, R0_EXP, 8'h3C, 1'b0, 1'b0};
    // Write accepted together with the clear request, then bypass is off in SWEEP.
    vecs[7] = '{1'b1, 3'd2, 8'hFF, 3'd2, 3'd3, 1'b1, 8'hFF, 8'hA5, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 1'b0, 8'hFF, 8'hA5, 1'b1, 1'b0};

    apply_reset();
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb, vecs[i].req);
      check($sformatf("vec%0d_rd_a", i), 32'(s_a), 32'(vecs[i].exp_a));
      check($sformatf("vec%0d_rd_b", i), 32'(s_b), 32'(vecs[i].exp_b));
      check($sformatf("vec%0d_busy", i), 32'(s_busy), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_done", i), 32'(s_done), 32'(vecs[i].exp_done));
    end

    // ---- full clear sweep: fill, request, write during busy is lost ----
    apply_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 3'(i), 8'(8'h11 * (i + 1)), 3'(i), 3'd0, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
      check("fill_rd_a", 32'(s_a), 32'(8'h11 * (i + 1)));
    end
    step(1'b0, 3'd0, 8'h00, 3'd0, 3'd1, 1'b1);
    busy_cnt = 0; done_idx = -1; done_seen = 0;
    for (int c = 1; c <= 12; c++) begin
      step(c <= 8, 3'd2, 8'hFF, 3'd2, 3'd7, 1'b0);
      if (s_busy) busy_cnt++;
      if (s_done && done_idx < 0) done_idx = c;
    end
    check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
    check("sweep_done_cycle", 32'(done_idx), 32'd9);
    check("sweep_done_count", 32'(done_seen), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 3'd0, 8'h00, 3'(i), 3'(i), 1'b0);
      check("cleared_rd_a", 32'(s_a), 32'h0);
      check("cleared_rd_b", 32'(s_b), 32'h0);
    end

    // ---- reset in the middle of a sweep ----
    apply_reset();
    step(1'b1, 3'd6, 8'hBB, 3'd6, 3'd1, 1'b0);
    step(1'b1, 3'd7, 8'hCC, 3'd6, 3'd7, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b0, 3'd0, 8'h00, 3'd6, 3'd7, 1'b0);
    check("midsweep_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("midsweep_busy_reset", 32'(busy), 32'h0);
    check("midsweep_done_reset", 32'(done), 32'h0);
    check("midsweep_rd_a_reset", 32'(rda), 32'h0);
    check("midsweep_rd_b_reset", 32'(rdb), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 12; c++) step(1'b0, 3'd0, 8'h00, 3'(c), 3'd6, 1'b0);
    check("midsweep_no_done", 32'(done_seen), 32'd0);
    step(1'b1, 3'd1, 8'h5A, 3'd0, 3'd2, 1'b0);
    step(1'b0, 3'd0, 8'h00, 3'd1, 3'd1, 1'b0);
    check("post_reset_write_a", 32'(s_a), 32'h5A);
    check("post_reset_write_b", 32'(s_b), 32'h5A);

    // ---- clear request held high: back-to-back sweeps ----
    step(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1);
    done_seen = 0;
    for (int c = 1; c <= 30; c++) begin
      step(1'b0, 3'd0, 8'h00, 3'd1, 3'd2, 1'b1);
      busy_h[c] = s_busy;
      done_h[c] = s_done;
    end
    check("held_done_count", 32'(done_seen), 32'd3);
    check("held_done_c9", 32'(done_h[9]), 32'h1);
    check("held_idle_c10", 32'({busy_h[10], done_h[10]}), 32'h0);
    check("held_busy_c11", 32'(busy_h[11]), 32'h1);
    check("held_done_c19", 32'(done_h[19]), 32'h1);
    check("held_idle_c20", 32'({busy_h[20], done_h[20]}), 32'h0);
    for (int c = 0; c < 12; c++) step(1'b0, 3'd0, 8'h00, 3'(c), 3'(c + 1), 1'b0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
